// File: rtl/vcdemux_ibuf.sv
// Link receive side: steers VC-tagged flits into per-VC FWFT FIFOs, checks packet framing, returns credits.
// Optional build macro VCDEMUX_DROPCNT_EN adds the saturating dropped-flit counter output odrop.
module vcdemux_ibuf #(
  parameter int NVCH  = 2,
  parameter int VCHW  = 1,
  parameter int DEPTH = 4,
  parameter int DATAW = 34
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  ivalid,
  input  logic [DATAW-1:0]      idata,
  input  logic [VCHW-1:0]       ivch,
  input  logic [NVCH-1:0]       ord,
  output logic [NVCH-1:0]       ovalid,
  output logic [NVCH*DATAW-1:0] odata,
  output logic [NVCH-1:0]       ohead,
  output logic [NVCH-1:0]       ocredit,
  output logic                  oerr
`ifdef VCDEMUX_DROPCNT_EN
  ,
  output logic [7:0]            odrop
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } vc_state_t;

  logic [1:0]      ftype;
  logic            vch_ok;
  logic [NVCH-1:0] drop_vc;
  logic            drop;
  logic            oerr_reg;

  assign ftype = idata[DATAW-1:DATAW-2];

  // Out-of-range VC numbers only exist when NVCH is not a power of two.
  generate
    if (NVCH < (1 << VCHW)) begin : g_vch_chk
      assign vch_ok = (ivch < VCHW'(NVCH));
    end else begin : g_vch_all
      assign vch_ok = 1'b1;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NVCH; gi++) begin : g_vc
      logic [DATAW-1:0] mem [DEPTH];
      logic [PW-1:0]    wptr_reg;
      logic [PW-1:0]    rptr_reg;
      logic [CW-1:0]    cnt_reg;
      vc_state_t        state_reg;
      logic             credit_reg;
      logic             sel;
      logic             frame_ok;
      logic             full;
      logic             rd;
      logic             accept;
      logic             nonempty;

      assign sel      = ivalid && vch_ok && (ivch == VCHW'(gi));
      // IDLE wants a head-class type (x1), BUSY wants body/tail (x0).
      assign frame_ok = (state_reg == IDLE) ? ftype[0] : ~ftype[0];
      assign full     = (cnt_reg == CW'(DEPTH));
      assign nonempty = (cnt_reg != '0);
      assign rd       = ord[gi] && nonempty;
      // A simultaneous dequeue frees the slot, so a full FIFO still accepts.
      assign accept   = sel && frame_ok && (!full || ord[gi]);
      assign drop_vc[gi] = sel && !accept;

      always_ff @(posedge clk) begin
        if (accept) begin
          mem[wptr_reg] <= idata;
        end
      end

      always_ff @(posedge clk) begin
        if (rst_) begin
          wptr_reg   <= '0;
          rptr_reg   <= '0;
          cnt_reg    <= '0;
          state_reg  <= IDLE;
          credit_reg <= 1'b0;
        end else begin
          credit_reg <= rd;
          if (accept) begin
            wptr_reg <= wptr_reg + PW'(1);
          end
          if (rd) begin
            rptr_reg <= rptr_reg + PW'(1);
          end
          case ({accept, rd})
            2'b10:   cnt_reg <= cnt_reg + CW'(1);
            2'b01:   cnt_reg <= cnt_reg - CW'(1);
            default: cnt_reg <= cnt_reg;
          endcase
          if (accept) begin
            case (state_reg)
              IDLE:    if (ftype == 2'b01) state_reg <= BUSY;
              BUSY:    if (ftype == 2'b10) state_reg <= IDLE;
              default: state_reg <= IDLE;
            endcase
          end
        end
      end

      assign ovalid[gi]                 = nonempty;
      assign odata[gi*DATAW +: DATAW]   = nonempty ? mem[rptr_reg] : '0;
      assign ohead[gi]                  = nonempty && mem[rptr_reg][DATAW-2];
      assign ocredit[gi]                = credit_reg;
    end
  endgenerate

  assign drop = (ivalid && !vch_ok) || (|drop_vc);

  always_ff @(posedge clk) begin
    if (rst_) begin
      oerr_reg <= 1'b0;
    end else if (drop) begin
      oerr_reg <= 1'b1;
    end
  end

  assign oerr = oerr_reg;

`ifdef VCDEMUX_DROPCNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst_) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign odrop = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_vcdemux_ibuf.sv
// Scoreboard bench for vcdemux_ibuf: directed flits with hand-marked accept/drop,
// a negedge monitor compares every output against per-VC expected queues.
module tb_vcdemux_ibuf;
  localparam int NVCH  = 2;
  localparam int VCHW  = 1;
  localparam int DEPTH = 4;
  localparam int DATAW = 34;

  logic                  clk = 1'b0;
  logic                  rst_ = 1'b1;
  logic                  ivalid = 1'b0;
  logic [DATAW-1:0]      idata = '0;
  logic [VCHW-1:0]       ivch = '0;
  logic [NVCH-1:0]       ord = '0;
  logic [NVCH-1:0]       ovalid;
  logic [NVCH*DATAW-1:0] odata;
  logic [NVCH-1:0]       ohead;
  logic [NVCH-1:0]       ocredit;
  logic                  oerr;
`ifdef VCDEMUX_DROPCNT_EN
  logic [7:0]            odrop;
`endif

  vcdemux_ibuf #(.NVCH(NVCH), .VCHW(VCHW), .DEPTH(DEPTH), .DATAW(DATAW)) dut (
    .clk(clk), .rst_(rst_), .ivalid(ivalid), .idata(idata), .ivch(ivch), .ord(ord),
    .ovalid(ovalid), .odata(odata), .ohead(ohead), .ocredit(ocredit), .oerr(oerr)
`ifdef VCDEMUX_DROPCNT_EN
    , .odrop(odrop)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected-state model, advanced at each negedge to represent the coming edge.
  logic [DATAW-1:0] expq [NVCH][$];
  logic             exp_acc = 1'b0;
  logic [NVCH-1:0]  exp_cred = '0;
  logic             exp_err = 1'b0;
  int               exp_drops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DATAW-1:0] flit(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  always @(negedge clk) begin
    logic [NVCH-1:0] deq;
    deq = '0;
    for (int k = 0; k < NVCH; k++) begin
      chk("ovalid", ovalid[k], expq[k].size() != 0);
      if (expq[k].size() != 0) begin
        chk("odata", odata[k*DATAW +: DATAW], expq[k][0]);
        chk("ohead", ohead[k], expq[k][0][DATAW-2]);
      end else begin
        chk("odata_empty", odata[k*DATAW +: DATAW], '0);
        chk("ohead_empty", ohead[k], 1'b0);
      end
    end
    chk("ocredit", ocredit, exp_cred);
    chk("oerr", oerr, exp_err);
`ifdef VCDEMUX_DROPCNT_EN
    chk("odrop", odrop, exp_drops);
`endif
    if (rst_) begin
      for (int k = 0; k < NVCH; k++) expq[k].delete();
      exp_cred  = '0;
      exp_err   = 1'b0;
      exp_drops = 0;
    end else begin
      for (int k = 0; k < NVCH; k++) begin
        deq[k] = ord[k] && (expq[k].size() != 0);
        if (deq[k]) void'(expq[k].pop_front());
      end
      if (ivalid) begin
        if (exp_acc) begin
          expq[ivch].push_back(idata);
        end else begin
          exp_err = 1'b1;
          if (exp_drops < 255) exp_drops++;
        end
      end
      exp_cred = deq;
    end
  end

  task automatic send(input int vc, input logic [1:0] t, input logic [31:0] p,
                      input logic [NVCH-1:0] rd, input logic acc);
    ivalid  = 1'b1;
    ivch    = VCHW'(vc);
    idata   = flit(t, p);
    ord     = rd;
    exp_acc = acc;
    $display("txn vc=%0d type=%b payload=%h ord=%b expect=%s", vc, t, p, rd, acc ? "accept" : "drop");
    @(posedge clk); #1;
    ivalid  = 1'b0;
    ord     = '0;
    exp_acc = 1'b0;
  endtask

  task automatic idle(input logic [NVCH-1:0] rd);
    ivalid = 1'b0;
    ord    = rd;
    @(posedge clk); #1;
    ord    = '0;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    @(posedge clk); #1;
    rst_ = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;
    chk("rst_ovalid", ovalid, 2'b00);
    chk("rst_oerr", oerr, 1'b0);

    // Basic latency: head+tail to VC0, visible next cycle, credit after dequeue.
    send(0, 2'b11, 32'h0000_1234, 2'b00, 1'b1);
    chk("lat_ovalid", ovalid, 2'b01);
    chk("lat_odata", odata[DATAW-1:0], 34'h3_0000_1234);
    chk("lat_ohead", ohead, 2'b01);
    idle(2'b01);
    chk("lat_ovalid_after", ovalid, 2'b00);
    chk("lat_credit", ocredit, 2'b01);
    idle(2'b00);
    chk("lat_credit_clear", ocredit, 2'b00);

    // Full VC0 inside a packet, then a body flit together with a dequeue.
    send(0, 2'b01, 32'hA000_0001, 2'b00, 1'b1);
    send(0, 2'b00, 32'hA000_0002, 2'b00, 1'b1);
    send(0, 2'b00, 32'hA000_0003, 2'b00, 1'b1);
    send(0, 2'b00, 32'hA000_0004, 2'b00, 1'b1);
    send(0, 2'b00, 32'hA000_0005, 2'b01, 1'b1);
    chk("full_rd_credit", ocredit, 2'b01);
    chk("full_rd_oerr", oerr, 1'b0);
    chk("full_rd_odata", odata[DATAW-1:0], 34'h0_A000_0002);
    repeat (4) idle(2'b01);
    send(0, 2'b10, 32'hA000_0006, 2'b00, 1'b1);
    idle(2'b01);
    idle(2'b00);

    // Parallel credits.
    send(0, 2'b11, 32'hB000_0000, 2'b00, 1'b1);
    send(1, 2'b11, 32'hB000_0001, 2'b00, 1'b1);
    chk("par_ovalid", ovalid, 2'b11);
    idle(2'b11);
    chk("par_credit", ocredit, 2'b11);
    chk("par_ovalid_after", ovalid, 2'b00);
    idle(2'b00);
    chk("par_credit_clear", ocredit, 2'b00);

    // Packet framing on VC1 to full, then an overflow head is dropped.
    send(1, 2'b01, 32'hC000_0001, 2'b00, 1'b1);
    send(1, 2'b00, 32'hC000_0002, 2'b00, 1'b1);
    send(1, 2'b00, 32'hC000_0003, 2'b00, 1'b1);
    send(1, 2'b10, 32'hC000_0004, 2'b00, 1'b1);
    chk("frm_oerr_clean", oerr, 1'b0);
    send(1, 2'b01, 32'hC000_0005, 2'b00, 1'b0);
    chk("frm_overflow_oerr", oerr, 1'b1);
    repeat (4) idle(2'b10);

    // Framing errors: body to IDLE VC1, head to BUSY VC0.
    send(1, 2'b00, 32'hD000_0001, 2'b00, 1'b0);
    chk("ferr_vc1_ovalid", ovalid[1], 1'b0);
    send(0, 2'b01, 32'hD000_0002, 2'b00, 1'b1);
    send(0, 2'b11, 32'hD000_0003, 2'b00, 1'b0);
    send(0, 2'b00, 32'hD000_0004, 2'b00, 1'b1);
    send(0, 2'b10, 32'hD000_0005, 2'b00, 1'b1);
    repeat (3) idle(2'b01);

    // Reset mid-packet discards buffered flits and returns FSMs to IDLE.
    do_reset();
    send(0, 2'b01, 32'hE000_0001, 2'b00, 1'b1);
    send(0, 2'b00, 32'hE000_0002, 2'b00, 1'b1);
    send(0, 2'b00, 32'hE000_0003, 2'b00, 1'b1);
    do_reset();
    chk("rstmid_ovalid", ovalid, 2'b00);
    chk("rstmid_ocredit", ocredit, 2'b00);
    chk("rstmid_oerr", oerr, 1'b0);
    send(0, 2'b00, 32'hE000_0004, 2'b00, 1'b0);
    chk("rstmid_drop_oerr", oerr, 1'b1);
    chk("rstmid_drop_ovalid", ovalid, 2'b00);
`ifdef VCDEMUX_DROPCNT_EN
    chk("rstmid_odrop", odrop, 8'd1);
`endif
    idle(2'b00);
    idle(2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vcdemux_ibuf.md
Name: vcdemux_ibuf

Overview:
- Input-port receive side of the router link: the counterpart to the output-side VC multiplexer.
- Accepts one flit per cycle tagged with a VC number and steers it into a per-VC FIFO.
- Tracks packet framing (head..tail) per VC.
- Presents each VC's oldest flit to the router core, and returns one credit pulse per VC each time a flit is dequeued.

Parameters:
- NVCH, 2, number of virtual channels.
- VCHW, 1, width of VC index (clog2(NVCH), minimum 1).
- DEPTH, 4, flits per VC FIFO (power of 2, >=2).
- DATAW, 34, flit width. Bits [DATAW-1:DATAW-2] carry the flit type: 01 head, 00 body, 10 tail, 11 head+tail.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_  in  1  synchronous reset, active-high (rst_=1 resets on the next posedge).
- ivalid  in  1  flit present on link this cycle.
- idata  in  DATAW  incoming flit.
- ivch  in  VCHW  target VC of incoming flit.
- ord  in  NVCH  per-VC dequeue request from router core.
- ovalid  out  NVCH  per-VC "FIFO non-empty".
- odata  out  NVCH*DATAW  per-VC oldest flit; VC k occupies [k*DATAW +: DATAW].
- ohead  out  NVCH  oldest flit of VC k is head or head+tail.
- ocredit  out  NVCH  registered one-cycle credit pulse per dequeued flit.
- oerr  out  1  sticky protocol/overflow error flag.

Behaviour:
Reset:
- All FIFOs are emptied and pointers are zeroed.
- All VC states go to IDLE.
- ovalid=0, ohead=0, ocredit=0, oerr=0, odata=0.

FIFO:
- Registered storage with first-word-fall-through.
- A flit written at edge t is visible on ovalid/odata after edge t (1-cycle latency).
- odata for an empty VC is all zeros.
- Occupancy counter is 0..DEPTH. Pointers wrap modulo DEPTH.

Write accept, for VC v=ivch when ivalid=1:
- ivch >= NVCH: flit dropped, oerr set.
- FIFO full and ord[v]=0: flit dropped, oerr set, state unchanged.
- FIFO full and ord[v]=1 in the same cycle: flit accepted, occupancy stays DEPTH.
- FIFO empty and ord[v]=1: the read is ignored because ovalid[v]=0; the write proceeds normally.

Per-VC framing FSM:
- States are IDLE (expect head) and BUSY (inside packet).
- IDLE + head (01): accept, go to BUSY.
- IDLE + head+tail (11): accept, stay IDLE.
- IDLE + body/tail (00/10): drop, set oerr, stay IDLE.
- BUSY + body (00): accept, stay BUSY.
- BUSY + tail (10): accept, go to IDLE.
- BUSY + head/head+tail: drop, set oerr, stay BUSY.
- A dropped flit never changes occupancy or FSM state, except where the transitions above state otherwise.
- The FSM advances only on accepted flits. Dequeue does not affect the FSM.

Dequeue and credit:
- Dequeue happens when ord[k] & ovalid[k]; the read pointer advances at that edge.
- ocredit[k] is 1 for exactly the following cycle.
- Multiple VCs may dequeue and credit in the same cycle.
- Credits are never generated for dropped flits.
- ord[k] with ovalid[k]=0 has no effect.

oerr:
- Sticky; cleared only by reset.
- Reset mid-packet discards all buffered flits and returns every FSM to IDLE.
- No credit is issued for flits discarded by reset.

Optional Feature:
Macro: VCDEMUX_DROPCNT_EN
- Defined:
  - Adds output port odrop (8 bits).
  - odrop is a saturating count of dropped flits, +1 per drop, holding at 255.
  - Reset to 0.
  - oerr behaviour is unchanged.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Basic latency: reset, then ivalid=1, ivch=0, idata type 11 payload 0x0000_1234 at cycle 1. Required: ovalid=01, ohead[0]=1, odata[0] = that flit at cycle 2. ord[0]=1 at cycle 2 gives ovalid=00 and ocredit=01 at cycle 3.
- Packet framing: VC1 receives head, body, body, tail on consecutive cycles with no reads. Required: occupancy reaches 4, FSM returns to IDLE, oerr=0. A 5th flit (head) to VC1 is dropped and oerr=1.
- Full plus simultaneous read: VC0 full (4 flits, inside packet), then ivalid to VC0 with a body flit and ord[0]=1 in the same cycle. Required: flit accepted, occupancy stays 4, ocredit[0]=1 next cycle, oerr=0.
- Framing error: a body flit to an IDLE VC1 is dropped; oerr=1, ovalid[1] unchanged. A head flit to a BUSY VC0 is dropped and the FSM stays BUSY.
- Parallel credits: VC0 and VC1 each hold 1 flit, ord=11. Required: ovalid=00 and ocredit=11 next cycle; then ocredit=00.
- Reset mid-packet: VC0 holds 3 flits in BUSY, assert rst_=1 for one cycle. Required: ovalid=00, ocredit=00, oerr=0, and a body flit afterwards is dropped (FSM IDLE). With VCDEMUX_DROPCNT_EN defined, odrop=1 after that drop.
